uart_io_sched: RTL
==================

Name: uart_io_sched

Overview:
Sequences and shares the single AXI4-Lite master port to the UART peripheral between N_REQ requesters, e.g. core IN/OUT and a debug loader.
- Each requester issues byte-level IN (receive) or OUT (transmit) requests.
- The block polls the UART status register, then performs the data read or write, then returns a one-cycle response.
- Replaces per-requester ad-hoc AXI sequencing; the core's stall logic waits on RSP_VALID.

Parameters:
N_REQ, 2, number of requesters (2..4)
STAT_ADDR, 4'h8, UART status register address
RX_ADDR, 4'h0, UART receive data address
TX_ADDR, 4'h4, UART transmit data address
RX_VALID_BIT, 0, status bit: RX FIFO has data
TX_FULL_BIT, 3, status bit: TX FIFO full
POLL_MAX, 1024, failed status polls before timeout (only with UART_POLL_TIMEOUT_EN)

Ports:
CLK  in  1  clock
RST_N  in  1  reset, synchronous, active-low
REQ_VALID  in  N_REQ  per-requester request, held until its RSP_VALID
REQ_WRITE  in  N_REQ  1=OUT, 0=IN
REQ_WDATA  in  8*N_REQ  OUT byte, slice i for requester i
RSP_VALID  out  N_REQ  one-cycle completion pulse to the granted requester
RSP_RDATA  out  8  IN byte, valid with RSP_VALID
RSP_ERR  out  1  nonzero RRESP/BRESP or timeout, valid with RSP_VALID
ARADDR/ARVALID/ARREADY  out/out/in  4/1/1  AXI-Lite read address
RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  AXI-Lite read data
AWADDR/AWVALID/AWREADY  out/out/in  4/1/1  AXI-Lite write address
WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  AXI-Lite write data
BRESP/BVALID/BREADY  in/in/out  2/1/1  AXI-Lite write response

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer to requester 0, poll counter 0. Reset mid-transaction drops every VALID/READY the next edge; the in-flight slave transaction is abandoned, since the slave shares the reset.
- All outputs are registered. A VALID is never deasserted before its READY and never depends combinationally on READY.

State machine:
- IDLE: if any REQ_VALID, grant the first requester at or after the pointer. Latch its grant index, WRITE and WDATA. Go to STAT_AR.
- STAT_AR: ARADDR=STAT_ADDR, ARVALID=1. On ARREADY, drop ARVALID and go to STAT_R.
- STAT_R: RREADY=1. On RVALID:
  - IN: RDATA[RX_VALID_BIT]=0 means repoll (STAT_AR); otherwise go to DATA_AR.
  - OUT: RDATA[TX_FULL_BIT]=1 means repoll; otherwise go to DATA_AW.
  - RRESP≠0 means go to DONE with error.
- DATA_AR: ARADDR=RX_ADDR. Handshake as in STAT_AR, then DATA_R.
- DATA_R: RREADY=1. On RVALID, latch RDATA[7:0] and RRESP, then go to DONE.
- DATA_AW: AWADDR=TX_ADDR, WDATA={24'b0,byte}, WSTRB=4'b0001. AWVALID and WVALID rise together and each drops independently on its READY. Leave for DATA_B once both have completed; same-cycle completion is allowed.
- DATA_B: BREADY=1. On BVALID, latch BRESP, then go to DONE.
- DONE: RSP_VALID[grant]=1 for one cycle; RSP_ERR=(resp≠OKAY). Pointer becomes grant+1 mod N_REQ. Return to IDLE.

Timing and arbitration rules:
- Zero-wait slave: RSP_VALID is asserted 5 cycles after the IDLE cycle that grants, for both IN and OUT. A minimum of 1 IDLE cycle separates back-to-back operations.
- Requester dropping REQ_VALID mid-operation: the operation still completes and the pulse is still issued.
- Simultaneous requests: strict round-robin, with no requester starved beyond N_REQ-1 operations.

Optional Feature:
UART_POLL_TIMEOUT_EN
- Defined: each repoll increments a counter. On reaching POLL_MAX the block goes to DONE with RSP_ERR=1 and RSP_RDATA=0. The counter clears on each grant.
- Undefined: polling is unbounded and the counter logic is absent.

Decomposition:
- Package uart_io_pkg holds:
  - the state enum (IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, DATA_AW, DATA_B, DONE)
  - default address constants and status bit indices
  - RESP_OKAY=2'b00
- Sub-module uart_rr_arb: round-robin grant from request vector and pointer, combinational, one-hot plus index out.

Test Plan:
- Req0 IN, zero-wait slave, status 0x01, RX 0x5A → AR addr 8 then 0; RSP_VALID[0] 5 cycles after grant; RSP_RDATA=0x5A; RSP_ERR=0.
- Req1 OUT 0x41, status 0x08 for 3 polls then 0x00 → 4 status reads; AW addr 4; WDATA=0x00000041; WSTRB=0001; RSP_VALID[1] once.
- Both valid from reset, each issuing 3 ops → grants 0,1,0,1,0,1.
- Slave returns AWREADY 2 cycles before WREADY, then BRESP=2'b10 → AWVALID drops first, WVALID held; RSP_ERR=1.
- RST_N asserted in DATA_R with RREADY high → next edge all outputs 0 and state IDLE; new request then completes normally.
- With UART_POLL_TIMEOUT_EN, POLL_MAX=4, IN with status always 0 → 4 polls, then RSP_ERR=1, RSP_RDATA=0.

Source files
------------

// File: rtl/uart_io_pkg.sv
// uart_io_pkg: shared types and constants for the UART I/O scheduler.
// Holds the FSM encoding, the default UART register map, the status bit
// positions and the AXI response code helper.
package uart_io_pkg;

   // Scheduler FSM. The encodings are fixed so waveforms stay readable
   // against older builds of this block.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      STAT_AR = 3'd1,
      STAT_R  = 3'd2,
      DATA_AR = 3'd3,
      DATA_R  = 3'd4,
      DATA_AW = 3'd5,
      DATA_B  = 3'd6,
      DONE    = 3'd7
   } state_t;

   // Default UART register map (byte addresses on the 4-bit AXI-Lite bus)
   localparam logic [3:0] STAT_ADDR_DEF = 4'h8;
   localparam logic [3:0] RX_ADDR_DEF   = 4'h0;
   localparam logic [3:0] TX_ADDR_DEF   = 4'h4;

   // Status register bit positions
   localparam int RX_VALID_BIT_DEF = 0;
   localparam int TX_FULL_BIT_DEF  = 3;

   // Failed status polls tolerated before an operation is abandoned
   localparam int POLL_MAX_DEF = 1024;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Any response other than OKAY is reported to the requester as an error.
   function automatic logic resp_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: round-robin request selector.
// Latency: combinational, no state.
// Backpressure: none; the caller samples the grant only when it can accept it.
// Ports: req (request vector), ptr (highest-priority index), gnt_oh (one-hot
// grant), gnt_idx (binary grant index), gnt_vld (any request present).
module uart_rr_arb #(
   parameter int N_REQ = 2,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt_oh,
   output logic [IW-1:0]    gnt_idx,
   output logic             gnt_vld
);

   // Scan requesters starting at ptr and wrapping; the first active one wins.
   always_comb begin
      int j;
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      j       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!gnt_vld && req[j]) begin
            gnt_vld    = 1'b1;
            gnt_oh[j]  = 1'b1;
            gnt_idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_io_sched.sv
// uart_io_sched: shares one AXI4-Lite master port to the UART among N_REQ
// byte-level IN/OUT requesters (status poll, then data access, then a
// one-cycle response pulse).
// Latency: with a zero-wait slave, RSP_VALID rises 5 cycles after the
// granting IDLE cycle; at least one IDLE cycle separates operations.
// Backpressure: every AXI VALID is held until its READY; requesters are
// stalled by holding REQ_VALID until their RSP_VALID pulse.
// Ports: CLK, RST_N (synchronous, active-low); REQ_VALID/REQ_WRITE/REQ_WDATA
// per requester; RSP_VALID/RSP_RDATA/RSP_ERR response; AXI-Lite AR/R/AW/W/B.
// Optional build macro UART_POLL_TIMEOUT_EN: bounds status polling to
// POLL_MAX failed polls, after which the operation completes with an error.
module uart_io_sched
   import uart_io_pkg::*;
#(
   parameter int         N_REQ        = 2,
   parameter logic [3:0] STAT_ADDR    = STAT_ADDR_DEF,
   parameter logic [3:0] RX_ADDR      = RX_ADDR_DEF,
   parameter logic [3:0] TX_ADDR      = TX_ADDR_DEF,
   parameter int         RX_VALID_BIT = RX_VALID_BIT_DEF,
   parameter int         TX_FULL_BIT  = TX_FULL_BIT_DEF
`ifdef UART_POLL_TIMEOUT_EN
   ,
   parameter int         POLL_MAX     = POLL_MAX_DEF
`endif
) (
   input  logic               CLK,
   input  logic               RST_N,
   // requester side
   input  logic [N_REQ-1:0]   REQ_VALID,
   input  logic [N_REQ-1:0]   REQ_WRITE,
   input  logic [8*N_REQ-1:0] REQ_WDATA,
   output logic [N_REQ-1:0]   RSP_VALID,
   output logic [7:0]         RSP_RDATA,
   output logic               RSP_ERR,
   // AXI-Lite read address / data
   output logic [3:0]         ARADDR,
   output logic               ARVALID,
   input  logic               ARREADY,
   input  logic [31:0]        RDATA,
   input  logic [1:0]         RRESP,
   input  logic               RVALID,
   output logic               RREADY,
   // AXI-Lite write address / data / response
   output logic [3:0]         AWADDR,
   output logic               AWVALID,
   input  logic               AWREADY,
   output logic [31:0]        WDATA,
   output logic [3:0]         WSTRB,
   output logic               WVALID,
   input  logic               WREADY,
   input  logic [1:0]         BRESP,
   input  logic               BVALID,
   output logic               BREADY
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

   state_t            state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     grant_idx;
   logic [N_REQ-1:0]  grant_oh;
   logic              is_write;
   logic [7:0]        wbyte;

   logic [N_REQ-1:0]  arb_oh;
   logic [IW-1:0]     arb_idx;
   logic              arb_vld;
   logic              sel_write;
   logic [7:0]        sel_wdata;
   logic              stat_wait;
   logic              aw_fin;
   logic              w_fin;

`ifdef UART_POLL_TIMEOUT_EN
   localparam int PW = $clog2(POLL_MAX + 1);
   logic [PW-1:0]     poll_cnt;
`endif

   // Only the low byte of read data and the two status bits are consumed.
   logic unused_rdata;
   assign unused_rdata = ^RDATA[31:8];

   uart_rr_arb #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_arb (
      .req     (REQ_VALID),
      .ptr     (ptr),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // Write flag and byte of whichever requester the arbiter selects.
   always_comb begin
      sel_write = 1'b0;
      sel_wdata = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_oh[i]) begin
            sel_write = REQ_WRITE[i];
            sel_wdata = REQ_WDATA[i*8 +: 8];
         end
      end
   end

   // Status says "not yet": IN waits for RX data, OUT waits for TX room.
   assign stat_wait = is_write ? RDATA[TX_FULL_BIT] : !RDATA[RX_VALID_BIT];

   // A write channel is finished once its VALID is gone or accepted now.
   assign aw_fin = !AWVALID || AWREADY;
   assign w_fin  = !WVALID  || WREADY;

   // Response outputs are loaded on entry to DONE so the pulse is registered.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         ptr       <= '0;
         grant_idx <= '0;
         grant_oh  <= '0;
         is_write  <= 1'b0;
         wbyte     <= 8'h00;
         RSP_VALID <= '0;
         RSP_RDATA <= 8'h00;
         RSP_ERR   <= 1'b0;
         ARADDR    <= 4'h0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
         AWADDR    <= 4'h0;
         AWVALID   <= 1'b0;
         WDATA     <= 32'h0;
         WSTRB     <= 4'h0;
         WVALID    <= 1'b0;
         BREADY    <= 1'b0;
`ifdef UART_POLL_TIMEOUT_EN
         poll_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (arb_vld) begin
                  grant_idx <= arb_idx;
                  grant_oh  <= arb_oh;
                  is_write  <= sel_write;
                  wbyte     <= sel_wdata;
`ifdef UART_POLL_TIMEOUT_EN
                  poll_cnt  <= '0;
`endif
                  ARADDR    <= STAT_ADDR;
                  ARVALID   <= 1'b1;
                  state     <= STAT_AR;
               end
            end

            STAT_AR: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= STAT_R;
               end
            end

            STAT_R: begin
               if (RVALID) begin
                  RREADY <= 1'b0;
                  if (resp_err(RRESP)) begin
                     RSP_VALID <= grant_oh;
                     RSP_RDATA <= 8'h00;
                     RSP_ERR   <= 1'b1;
                     state     <= DONE;
                  end else if (stat_wait) begin
`ifdef UART_POLL_TIMEOUT_EN
                     if (poll_cnt == PW'(POLL_MAX - 1)) begin
                        RSP_VALID <= grant_oh;
                        RSP_RDATA <= 8'h00;
                        RSP_ERR   <= 1'b1;
                        state     <= DONE;
                     end else begin
                        poll_cnt <= poll_cnt + PW'(1);
                        ARADDR   <= STAT_ADDR;
                        ARVALID  <= 1'b1;
                        state    <= STAT_AR;
                     end
`else
                     ARADDR  <= STAT_ADDR;
                     ARVALID <= 1'b1;
                     state   <= STAT_AR;
`endif
                  end else if (is_write) begin
                     AWADDR  <= TX_ADDR;
                     AWVALID <= 1'b1;
                     WDATA   <= {24'h0, wbyte};
                     WSTRB   <= 4'b0001;
                     WVALID  <= 1'b1;
                     state   <= DATA_AW;
                  end else begin
                     ARADDR  <= RX_ADDR;
                     ARVALID <= 1'b1;
                     state   <= DATA_AR;
                  end
               end
            end

            DATA_AR: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= DATA_R;
               end
            end

            DATA_R: begin
               if (RVALID) begin
                  RREADY    <= 1'b0;
                  RSP_VALID <= grant_oh;
                  RSP_RDATA <= RDATA[7:0];
                  RSP_ERR   <= resp_err(RRESP);
                  state     <= DONE;
               end
            end

            // AW and W are independent; either may be accepted first.
            DATA_AW: begin
               if (AWREADY) AWVALID <= 1'b0;
               if (WREADY)  WVALID  <= 1'b0;
               if (aw_fin && w_fin) begin
                  BREADY <= 1'b1;
                  state  <= DATA_B;
               end
            end

            DATA_B: begin
               if (BVALID) begin
                  BREADY    <= 1'b0;
                  RSP_VALID <= grant_oh;
                  RSP_RDATA <= 8'h00;
                  RSP_ERR   <= resp_err(BRESP);
                  state     <= DONE;
               end
            end

            DONE: begin
               RSP_VALID <= '0;
               RSP_RDATA <= 8'h00;
               RSP_ERR   <= 1'b0;
               ptr       <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
